// File: rtl/lpc_io_dispatch.sv
// LPC I/O cycle dispatcher: decodes an LPC I/O address against four target
// windows, strobes the winning target and returns its completion upstream.
module lpc_io_dispatch #(
  parameter logic [15:0] BASE0   = 16'h0060,
  parameter logic [15:0] BASE1   = 16'h0064,
  parameter logic [15:0] BASE2   = 16'h0080,
  parameter logic [15:0] BASE3   = 16'h0000,
  parameter logic [15:0] MASK0   = 16'hFFFF,
  parameter logic [15:0] MASK1   = 16'hFFFF,
  parameter logic [15:0] MASK2   = 16'hFFF0,
  parameter logic [15:0] MASK3   = 16'h0000,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] lpc_addr_i,
  input  logic [7:0]  lpc_wdata_i,
  input  logic        lpc_data_wr_i,
  input  logic        lpc_data_req_i,
  output logic        lpc_wr_done_o,
  output logic        lpc_data_rd_o,
  output logic [7:0]  lpc_rdata_o,
  output logic [15:0] tgt_addr_o,
  output logic [7:0]  tgt_wdata_o,
  output logic [3:0]  tgt_wr_o,
  output logic [3:0]  tgt_rd_o,
  input  logic [3:0]  tgt_ack_i,
  input  logic [31:0] tgt_rdata_i,
  output logic        busy_o,
  output logic        err_unmapped_o,
  output logic        err_timeout_o
);

  localparam int NT = 4;
  localparam logic [NT-1:0][15:0] BASE = {BASE3, BASE2, BASE1, BASE0};
  localparam logic [NT-1:0][15:0] MASK = {MASK3, MASK2, MASK1, MASK0};

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;

  logic          wr_q, rd_q, wr_arm_q, rd_arm_q;
  logic          wr_edge, rd_edge, start;
  logic [NT-1:0] hit;
  logic          any_hit;
  logic [1:0]    sel_d, sel_q;
  logic          dir_wr_q, abort_q;
  logic [7:0]    cnt_q;
  logic          req_lvl, ack, aborting, tmo;

  // An input only becomes edge-capable once it has been seen low after reset,
  // so a request left high across reset is not mistaken for a new cycle.
  assign wr_edge = lpc_data_wr_i  & ~wr_q & wr_arm_q;
  assign rd_edge = lpc_data_req_i & ~rd_q & rd_arm_q;
  assign start   = (state_q == IDLE) & (wr_edge | rd_edge);

  for (genvar g = 0; g < NT; g++) begin : g_hit
    assign hit[g] = (((lpc_addr_i ^ BASE[g]) & MASK[g]) == 16'h0000) && (MASK[g] != 16'h0000);
  end

  assign any_hit = |hit;

  always_comb begin
    sel_d = 2'd0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (hit[i]) sel_d = 2'(i);
    end
  end

  assign req_lvl  = dir_wr_q ? lpc_data_wr_i : lpc_data_req_i;
  assign ack      = tgt_ack_i[sel_q];
  assign aborting = abort_q | ~req_lvl;
  assign tmo      = ~ack & (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = any_hit ? WAIT : DONE;
      // An aborted cycle still drains the target, then skips the handshake.
      WAIT: if (ack | tmo) state_d = aborting ? IDLE : DONE;
      DONE: if (!req_lvl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      wr_arm_q       <= 1'b0;
      rd_arm_q       <= 1'b0;
      sel_q          <= 2'd0;
      dir_wr_q       <= 1'b0;
      abort_q        <= 1'b0;
      cnt_q          <= 8'd0;
      tgt_addr_o     <= 16'h0000;
      tgt_wdata_o    <= 8'h00;
      tgt_wr_o       <= 4'h0;
      tgt_rd_o       <= 4'h0;
      lpc_rdata_o    <= 8'h00;
      err_unmapped_o <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      wr_q           <= lpc_data_wr_i;
      rd_q           <= lpc_data_req_i;
      if (!lpc_data_wr_i)  wr_arm_q <= 1'b1;
      if (!lpc_data_req_i) rd_arm_q <= 1'b1;
      tgt_wr_o       <= 4'h0;
      tgt_rd_o       <= 4'h0;
      err_unmapped_o <= 1'b0;
      err_timeout_o  <= 1'b0;

      if (start) begin
        tgt_addr_o  <= lpc_addr_i;
        tgt_wdata_o <= lpc_wdata_i;
        dir_wr_q    <= wr_edge;
        sel_q       <= sel_d;
        abort_q     <= 1'b0;
        cnt_q       <= 8'd0;
        if (any_hit) begin
          if (wr_edge) tgt_wr_o <= 4'b0001 << sel_d;
          else         tgt_rd_o <= 4'b0001 << sel_d;
        end else begin
          err_unmapped_o <= 1'b1;
          if (!wr_edge) lpc_rdata_o <= 8'hFF;
        end
      end

      if (state_q == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
        if (!req_lvl) abort_q <= 1'b1;
        // Read data only moves on a read that actually completes upstream.
        if (ack) begin
          if (!aborting && !dir_wr_q) lpc_rdata_o <= tgt_rdata_i[{sel_q, 3'b000} +: 8];
        end else if (tmo && !aborting) begin
          err_timeout_o <= 1'b1;
          if (!dir_wr_q) lpc_rdata_o <= 8'hFF;
        end
      end
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign lpc_wr_done_o = (state_q == DONE) &&  dir_wr_q;
  assign lpc_data_rd_o = (state_q == DONE) && !dir_wr_q;

endmodule

// File: tb/tb_lpc_io_dispatch.sv
// Directed bench for lpc_io_dispatch with a transaction-level reference model
// compared against the DUT on every falling clock edge.
module tb_lpc_io_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] lpc_addr_i = '0;
  logic [7:0]  lpc_wdata_i = '0;
  logic        lpc_data_wr_i = 1'b0;
  logic        lpc_data_req_i = 1'b0;
  logic        lpc_wr_done_o, lpc_data_rd_o;
  logic [7:0]  lpc_rdata_o;
  logic [15:0] tgt_addr_o;
  logic [7:0]  tgt_wdata_o;
  logic [3:0]  tgt_wr_o, tgt_rd_o;
  logic [3:0]  tgt_ack_i = '0;
  logic [31:0] tgt_rdata_i = {8'h00, 8'h77, 8'h66, 8'hA5};
  logic        busy_o, err_unmapped_o, err_timeout_o;

  localparam int TMO = 64;

  lpc_io_dispatch #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .lpc_addr_i(lpc_addr_i), .lpc_wdata_i(lpc_wdata_i),
    .lpc_data_wr_i(lpc_data_wr_i), .lpc_data_req_i(lpc_data_req_i),
    .lpc_wr_done_o(lpc_wr_done_o), .lpc_data_rd_o(lpc_data_rd_o),
    .lpc_rdata_o(lpc_rdata_o), .tgt_addr_o(tgt_addr_o), .tgt_wdata_o(tgt_wdata_o),
    .tgt_wr_o(tgt_wr_o), .tgt_rd_o(tgt_rd_o), .tgt_ack_i(tgt_ack_i),
    .tgt_rdata_i(tgt_rdata_i), .busy_o(busy_o),
    .err_unmapped_o(err_unmapped_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference windows (default parameters) and first-match decode.
  function automatic int lookup(input logic [15:0] a);
    logic [15:0] b [4];
    logic [15:0] m [4];
    b = '{16'h0060, 16'h0064, 16'h0080, 16'h0000};
    m = '{16'hFFFF, 16'hFFFF, 16'hFFF0, 16'h0000};
    for (int i = 0; i < 4; i++)
      if (m[i] != 0 && ((a & m[i]) == (b[i] & m[i]))) return i;
    return -1;
  endfunction

  // Model: a transaction is "open" from its accepting edge, "in flight" while
  // the target owes an answer, and "handshaking" while the done level is shown.
  bit          t_open, t_flight, t_is_wr, t_dropped, last_wr, last_rd;
  int          t_tgt, t_age;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata, e_rdata;
  logic [3:0]  e_twr, e_trd;
  bit          e_eunm, e_etmo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_open = 0; t_flight = 0; t_is_wr = 0; t_dropped = 0; t_tgt = 0; t_age = 0;
      last_wr = 1; last_rd = 1;
      e_addr = 0; e_wdata = 0; e_rdata = 0; e_twr = 0; e_trd = 0; e_eunm = 0; e_etmo = 0;
    end else begin
      bit lvl, wr_rise, rd_rise;
      lvl = t_is_wr ? lpc_data_wr_i : lpc_data_req_i;
      wr_rise = lpc_data_wr_i && !last_wr;
      rd_rise = lpc_data_req_i && !last_rd;
      e_twr = 0; e_trd = 0; e_eunm = 0; e_etmo = 0;
      if (!t_open) begin
        if (wr_rise || rd_rise) begin
          t_open = 1; t_is_wr = wr_rise;
          e_addr = lpc_addr_i; e_wdata = lpc_wdata_i;
          t_tgt = lookup(lpc_addr_i);
          if (t_tgt < 0) begin
            e_eunm = 1;
            if (!t_is_wr) e_rdata = 8'hFF;
          end else begin
            t_flight = 1; t_age = 0; t_dropped = 0;
            if (t_is_wr) e_twr = 4'(1 << t_tgt); else e_trd = 4'(1 << t_tgt);
          end
        end
      end else if (t_flight) begin
        t_age++;
        if (!lvl) t_dropped = 1;
        if (tgt_ack_i[t_tgt]) begin
          if (!t_dropped && !t_is_wr) e_rdata = tgt_rdata_i[8*t_tgt +: 8];
          t_flight = 0;
          if (t_dropped) t_open = 0;
        end else if (t_age == TMO) begin
          if (!t_dropped) begin
            e_etmo = 1;
            if (!t_is_wr) e_rdata = 8'hFF;
          end
          t_flight = 0;
          if (t_dropped) t_open = 0;
        end
      end else if (!lvl) begin
        t_open = 0;
      end
      last_wr = lpc_data_wr_i;
      last_rd = lpc_data_req_i;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",      busy_o,         t_open);
      chk("wr_done",   lpc_wr_done_o,  t_open && !t_flight && t_is_wr);
      chk("data_rd",   lpc_data_rd_o,  t_open && !t_flight && !t_is_wr);
      chk("rdata",     lpc_rdata_o,    e_rdata);
      chk("tgt_addr",  tgt_addr_o,     e_addr);
      chk("tgt_wdata", tgt_wdata_o,    e_wdata);
      chk("tgt_wr",    tgt_wr_o,       e_twr);
      chk("tgt_rd",    tgt_rd_o,       e_trd);
      chk("err_unm",   err_unmapped_o, e_eunm);
      chk("err_tmo",   err_timeout_o,  e_etmo);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] unm [3];
    int k;
    bit got;
    unm = '{16'h1234, 16'h0000, 16'h0090};

    // Reset with a read request already high: no cycle may start from it.
    rst = 1'b1;
    lpc_addr_i = 16'h0060; lpc_data_req_i = 1'b1;
    tick(2);
    chk("rst_busy",  busy_o, 0);
    chk("rst_rdata", lpc_rdata_o, 8'h00);
    cmp_en = 1'b1;
    rst = 1'b0;
    tick(3);
    chk("stale_req_busy", busy_o, 0);
    chk("stale_req_rd",   tgt_rd_o, 4'b0000);
    lpc_data_req_i = 1'b0;
    tick(2);

    // Read 0x0060, target 0 acks in the strobe cycle.
    lpc_addr_i = 16'h0060; lpc_data_req_i = 1'b1;
    tick(1);
    chk("A_strobe", tgt_rd_o, 4'b0001);
    tgt_ack_i = 4'b0001;
    tick(1);
    tgt_ack_i = 4'b0000;
    chk("A_rd",    lpc_data_rd_o, 1);
    chk("A_rdata", lpc_rdata_o, 8'hA5);
    tick(2);
    chk("A_hold",  lpc_data_rd_o, 1);
    lpc_data_req_i = 1'b0;
    tick(1);
    chk("A_rd_low", lpc_data_rd_o, 0);
    tick(1);

    // Read 0x0064, no ack from target 1; acks from others must be ignored.
    lpc_addr_i = 16'h0064; lpc_data_req_i = 1'b1;
    tick(1);
    chk("D_strobe", tgt_rd_o, 4'b0010);
    k = 0; got = 0;
    while (k < 100 && !got) begin
      tgt_ack_i = (k == 3 || k == 4) ? 4'b0101 : 4'b0000;
      @(negedge clk);
      k++;
      if (err_timeout_o) got = 1;
    end
    tgt_ack_i = 4'b0000;
    chk("D_tmo_cycles", k, 64);
    chk("D_rdata",      lpc_rdata_o, 8'hFF);
    chk("D_rd",         lpc_data_rd_o, 1);
    lpc_data_req_i = 1'b0;
    tick(2);

    // Write 0x3C to 0x0085, target 2 acks 3 cycles after the strobe.
    lpc_addr_i = 16'h0085; lpc_wdata_i = 8'h3C; lpc_data_wr_i = 1'b1;
    tick(1);
    chk("B_strobe", tgt_wr_o, 4'b0100);
    chk("B_addr",   tgt_addr_o, 16'h0085);
    chk("B_wdata",  tgt_wdata_o, 8'h3C);
    tick(3);
    chk("B_pre_done", lpc_wr_done_o, 0);
    tgt_ack_i = 4'b0100;
    tick(1);
    tgt_ack_i = 4'b0000;
    chk("B_done",  lpc_wr_done_o, 1);
    chk("B_rdata", lpc_rdata_o, 8'hFF);
    lpc_data_wr_i = 1'b0;
    tick(2);
    chk("B_idle",  busy_o, 0);

    // Unmapped reads: foreign address, disabled window, just past window 2.
    foreach (unm[i]) begin
      lpc_rdata_o_prep: begin
        lpc_addr_i = unm[i]; lpc_data_req_i = 1'b1;
      end
      tick(1);
      chk("C_err_unm", err_unmapped_o, 1);
      chk("C_rdata",   lpc_rdata_o, 8'hFF);
      chk("C_rd",      lpc_data_rd_o, 1);
      chk("C_nostrb",  tgt_rd_o, 4'b0000);
      lpc_data_req_i = 1'b0;
      tick(2);
    end

    // Simultaneous write and read edges resolve to a write.
    lpc_addr_i = 16'h0080; lpc_wdata_i = 8'h5A;
    lpc_data_wr_i = 1'b1; lpc_data_req_i = 1'b1;
    tick(1);
    chk("H_wr", tgt_wr_o, 4'b0100);
    chk("H_rd", tgt_rd_o, 4'b0000);
    tgt_ack_i = 4'b0100;
    tick(1);
    tgt_ack_i = 4'b0000;
    chk("H_done", lpc_wr_done_o, 1);
    lpc_data_wr_i = 1'b0; lpc_data_req_i = 1'b0;
    tick(2);

    // Write to 0x0060 aborted 2 cycles into WAIT, ack 5 cycles later.
    lpc_addr_i = 16'h0060; lpc_wdata_i = 8'h11; lpc_data_wr_i = 1'b1;
    tick(1);
    tick(2);
    lpc_data_wr_i = 1'b0;
    tick(5);
    chk("E_busy", busy_o, 1);
    tgt_ack_i = 4'b0001;
    tick(1);
    tgt_ack_i = 4'b0000;
    chk("E_idle",    busy_o, 0);
    chk("E_no_done", lpc_wr_done_o, 0);
    chk("E_no_err",  err_timeout_o, 0);
    tick(2);

    // Reset mid-WAIT, then a stale ack after release.
    lpc_addr_i = 16'h0060; lpc_data_req_i = 1'b1;
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("F_busy",  busy_o, 0);
    chk("F_rdata", lpc_rdata_o, 8'h00);
    chk("F_addr",  tgt_addr_o, 16'h0000);
    chk("F_rd",    lpc_data_rd_o, 0);
    tick(2);
    rst = 1'b0;
    tgt_ack_i = 4'b0001;
    tick(2);
    tgt_ack_i = 4'b0000;
    chk("F_stale_busy", busy_o, 0);
    chk("F_stale_rd",   lpc_data_rd_o, 0);
    lpc_data_req_i = 1'b0;
    tick(2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
